// File: rtl/hpdmc_initseq.sv
// SDRAM power-up sequencer: walks a fixed CSR write list into an HPDMC-style controller.
// Define HPDMC_INITSEQ_VERIFY_EN to compile in the timing-register readback check.
module hpdmc_initseq #(
    parameter logic [3:0]  csr_addr  = 4'h0,
    parameter logic [15:0] init_wait = 16'd20000,
    parameter logic [7:0]  cmd_gap   = 8'd8,
    parameter logic [12:0] mode_reg  = 13'h033,
    parameter logic [23:0] tim_val   = 24'h9A8312
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [13:0] csr_a,
    output logic        csr_we,
    output logic [31:0] csr_do,
    input  logic [31:0] csr_di
);

`ifdef HPDMC_INITSEQ_VERIFY_EN
    typedef enum logic [2:0] {StIdle, StWr, StWait, StRd, StDone} state_t;
`else
    typedef enum logic [2:0] {StIdle, StWr, StWait, StDone} state_t;
    logic unused_di;
    assign unused_di = ^csr_di;
`endif

    state_t      state;
    logic [2:0]  step;
    logic [15:0] cnt;
    logic        issue;
    logic [2:0]  issue_step;

    function automatic logic [1:0] step_off(input logic [2:0] s);
        case (s)
            3'd1, 3'd2, 3'd3, 3'd4: step_off = 2'd1;
            3'd5:                   step_off = 2'd2;
            default:                step_off = 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] step_data(input logic [2:0] s);
        case (s)
            3'd0:       step_data = 32'h0000_0007;
            3'd1:       step_data = 32'h0000_400B;
            3'd2, 3'd3: step_data = 32'h0000_000D;
            3'd4:       step_data = {13'd0, 2'b00, mode_reg, 4'hF};
            3'd5:       step_data = {8'd0, tim_val};
            3'd6:       step_data = 32'h0000_0004;
            default:    step_data = 32'h0;
        endcase
    endfunction

    function automatic logic [15:0] step_gap(input logic [2:0] s);
        case (s)
            3'd0:                   step_gap = init_wait;
            3'd1, 3'd2, 3'd3, 3'd4: step_gap = {8'd0, cmd_gap};
            default:                step_gap = 16'd0;
        endcase
    endfunction

    // issue: the next edge presents write number issue_step
    always_comb begin
        issue      = 1'b0;
        issue_step = step + 3'd1;
        case (state)
            StIdle, StDone: begin
                issue      = start;
                issue_step = 3'd0;
            end
`ifdef HPDMC_INITSEQ_VERIFY_EN
            StWr:   issue = (step != 3'd6) && (step != 3'd5) && (cnt == 16'd0);
            StRd:   issue = (cnt == 16'd0);
`else
            StWr:   issue = (step != 3'd6) && (cnt == 16'd0);
`endif
            StWait: issue = (cnt == 16'd1);
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= StIdle;
            step   <= 3'd0;
            cnt    <= 16'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            csr_a  <= 14'd0;
            csr_we <= 1'b0;
            csr_do <= 32'd0;
        end else begin
            csr_we <= 1'b0;
            csr_a  <= 14'd0;
            csr_do <= 32'd0;
            if (issue) begin
                state  <= StWr;
                step   <= issue_step;
                cnt    <= step_gap(issue_step);
                busy   <= 1'b1;
                csr_we <= 1'b1;
                csr_a  <= {csr_addr, 8'h00, step_off(issue_step)};
                csr_do <= step_data(issue_step);
                if (state == StIdle || state == StDone) begin
                    done <= 1'b0;
                    err  <= 1'b0;
                end
`ifdef HPDMC_INITSEQ_VERIFY_EN
                if (state == StRd && csr_di[23:0] != tim_val) err <= 1'b1;
`endif
            end else begin
                case (state)
                    StWr: begin
                        if (step == 3'd6) begin
                            state <= StDone;
                            step  <= 3'd0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef HPDMC_INITSEQ_VERIFY_EN
                        end else if (step == 3'd5) begin
                            // two read cycles: address, then registered data
                            state <= StRd;
                            cnt   <= 16'd1;
                            csr_a <= {csr_addr, 8'h00, 2'd2};
`endif
                        end else begin
                            state <= StWait;
                        end
                    end
                    StWait: cnt <= cnt - 16'd1;
`ifdef HPDMC_INITSEQ_VERIFY_EN
                    StRd: begin
                        cnt   <= cnt - 16'd1;
                        csr_a <= {csr_addr, 8'h00, 2'd2};
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/hpdmc_initseq.md
HPDMC_INITSEQ -- requirements
Module: hpdmc_initseq

Interface
REQ-001 The block SHALL have parameter csr_addr, default 4'h0: CSR bank of the target DRAM control interface, driven on csr_a[13:10].
REQ-002 The block SHALL have parameter init_wait, default 16'd20000: idle cycles after power-up write (tINIT).
REQ-003 The block SHALL have parameter cmd_gap, default 8'd8: idle cycles after each SDRAM command write (covers tRP/tRFC/tMRD).
REQ-004 The block SHALL have parameter mode_reg, default 13'h033: value for the LOAD MODE REGISTER address field.
REQ-005 The block SHALL have parameter tim_val, default 24'h9A8312: timing register image for CSR offset 2, bits [23:0].
REQ-006 The block SHALL have port sys_clk, input, 1: the only clock.
REQ-007 The block SHALL have port sys_rst, input, 1: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1: begin sequence; sampled only in IDLE.
REQ-009 The block SHALL have port busy, output, 1: sequence in progress.
REQ-010 The block SHALL have port done, output, 1: sequence complete.
REQ-011 The block SHALL have port err, output, 1: readback mismatch; only present in function, see REQ-030.
REQ-012 The block SHALL have port csr_a, output, 14: CSR address {csr_addr, 8'h00, offset[1:0]}.
REQ-013 The block SHALL have port csr_we, output, 1: one-cycle write strobe.
REQ-014 The block SHALL have port csr_do, output, 32: write data.
REQ-015 The block SHALL have port csr_di, input, 32: read data, valid one cycle after the address.

Function
REQ-016 The block SHALL be a CSR initiator; all outputs are registered.
REQ-017 While idle between writes, the block SHALL drive csr_we=0, csr_do=0, and csr_a=0.
REQ-018 Each write SHALL last exactly one cycle: csr_we=1 with csr_a/csr_do valid.
REQ-019 The block SHALL use states IDLE, WR, WAIT, RD (readback only), DONE; WR/WAIT SHALL step through a 7-entry write list with a 3-bit step counter.
REQ-020 In IDLE, the first write SHALL be driven in the cycle after the edge that samples start=1.
REQ-021 The write list and the following csr_we=0 gap SHALL be, in order:
  - W0: offset 0, data 32'h7 (bypass, sdram_rst, cke); gap init_wait.
  - W1: offset 1, data 32'h400B (PRECHARGE ALL, A10=1); gap cmd_gap.
  - W2: offset 1, data 32'hD (AUTO REFRESH); gap cmd_gap.
  - W3: offset 1, data 32'hD (AUTO REFRESH); gap cmd_gap.
  - W4: offset 1, data {13'd0, 2'b00, mode_reg, 4'hF} (LOAD MODE); gap cmd_gap.
  - W5: offset 2, data {8'd0, tim_val}; gap 0 (readback if enabled).
  - W6: offset 0, data 32'h4 (bypass=0, sdram_rst=0, cke=1).
REQ-022 The wait counter SHALL be 16 bits, loaded at the write cycle and counting down to zero; a gap of 0 SHALL make the next write immediately follow.
REQ-023 busy SHALL be 1 from the W0 cycle through the W6 cycle inclusive, and 0 otherwise.
REQ-024 done SHALL rise in the cycle after W6 and hold until reset or a new start.
REQ-025 start SHALL be ignored while busy; start in DONE SHALL clear done and err and rerun the sequence from W0.
REQ-026 Simultaneous start and sys_rst SHALL resolve to reset (no write issued).

Reset
REQ-027 On sys_rst=1, the block SHALL enter IDLE next edge with busy=0, done=0, err=0, csr_we=0, csr_a=0, csr_do=0, and counters=0.
REQ-028 On reset mid-sequence, the block SHALL abort with no further csr_we pulse; a partial sequence is not resumed.

Configuration
REQ-029 The macro HPDMC_INITSEQ_VERIFY_EN SHALL select whether readback is compiled in.
REQ-030 When HPDMC_INITSEQ_VERIFY_EN is defined: after W5, RD SHALL drive csr_a offset 2 with csr_we=0 for 2 cycles and capture csr_di in the second; if csr_di[23:0]!=tim_val, err=1 (sticky); W6 SHALL follow regardless.
REQ-031 When HPDMC_INITSEQ_VERIFY_EN is undefined: RD state SHALL be absent, W6 SHALL immediately follow W5, err SHALL be tied 0, and csr_di SHALL be unused.

Verification
REQ-032 Reset, then pulse start with init_wait=4 and cmd_gap=2 -> 7 csr_we pulses with data 7, 400B, D, D, (mode_reg<<4)|F, tim_val, 4; gaps 4,2,2,2,2,0 (+2 with VERIFY); done the cycle after the last pulse.
REQ-033 Model the slave (registered read, bank decode) with VERIFY_EN -> the slave ends with bypass=0, cke=1, and timing register==tim_val; err=0.
REQ-034 With VERIFY_EN, corrupt csr_di bit 3 during RD -> err=1 and done=1; W6 is still issued.
REQ-035 Assert sys_rst during the gap after W2 -> no further csr_we; next start reruns from W0 (data 7).
REQ-036 Pulse start during W3 wait, then in DONE -> the first is ignored (write count stays 7); the second clears done and reruns.
REQ-037 Set csr_addr=4'h5 -> every pulse has csr_a[13:10]=5 and csr_a[9:2]=0.
